// File: rtl/ysyx_23060236_axi_pkg.sv
// Shared constants, FSM state types and access-check helper for the AXI4-Lite SRAM responder.
package ysyx_23060236_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    // True when the size is illegal or the address is not naturally aligned for it.
    function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
        logic err;
        case (size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = lsb[0];
            SIZE_W:  err = (lsb != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ysyx_23060236_lat_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module ysyx_23060236_lat_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/ysyx_23060236_axi_sram.sv
// AXI4-Lite responder over a word-addressed SRAM with fixed read and write response latency.
module ysyx_23060236_axi_sram
    import ysyx_23060236_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    input  logic [2:0]  arsize,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    input  logic [2:0]  awsize,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
    // The handshake cycle and the response cycle bracket the wait state, so the
    // counter only has to cover the latency beyond two cycles.
    localparam int unsigned R_LOAD = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int unsigned W_LOAD = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0;
    localparam int unsigned R_CW   = $clog2(READ_LATENCY + 1);
    localparam int unsigned W_CW   = $clog2(WRITE_LATENCY + 1);

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    r_state_t    r_state;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic [31:0] r_src_addr;
    logic [2:0]  r_src_size;
    logic [31:0] r_off;
    logic        r_err;
    logic [IDX_W-1:0] r_idx;
    logic        r_cnt_load;
    logic        r_done;

    // With unit latency the sample happens on the handshake edge, so decode the live bus.
    assign r_src_addr = (r_state == R_IDLE) ? araddr : ar_addr_q;
    assign r_src_size = (r_state == R_IDLE) ? arsize : ar_size_q;
    assign r_off      = r_src_addr - BASE_ADDR;
    assign r_err      = (r_off >= SPAN) | size_err(r_src_size, r_src_addr[1:0]);
    assign r_idx      = r_off[IDX_W+1:2];
    assign arready    = (r_state == R_IDLE);
    assign r_cnt_load = (r_state == R_IDLE) && arvalid;

    ysyx_23060236_lat_cnt #(
        .WIDTH (R_CW)
    ) u_r_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (r_cnt_load),
        .load_val (R_CW'(R_LOAD)),
        .done     (r_done)
    );

    // Read FSM: accept AR, wait out the latency, hold R until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= R_IDLE;
            ar_addr_q <= '0;
            ar_size_q <= '0;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_addr_q <= araddr;
                        ar_size_q <= arsize;
                        if (READ_LATENCY == 1) begin
                            rdata   <= r_err ? 32'h0 : mem[r_idx];
                            rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
                            rvalid  <= 1'b1;
                            r_state <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_done) begin
                        rdata   <= r_err ? 32'h0 : mem[r_idx];
                        rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
                        rvalid  <= 1'b1;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state;
    logic        have_aw_q;
    logic        have_w_q;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] cur_addr;
    logic [2:0]  cur_size;
    logic [31:0] cur_data;
    logic [3:0]  cur_strb;
    logic [31:0] w_off;
    logic        w_err;
    logic [IDX_W-1:0] w_idx;
    logic        aw_hs;
    logic        w_hs;
    logic        w_both;
    logic        w_cnt_load;
    logic        w_done;
    logic        commit;

    assign awready  = ~have_aw_q;
    assign wready   = ~have_w_q;
    assign aw_hs    = awvalid & ~have_aw_q;
    assign w_hs     = wvalid & ~have_w_q;
    assign w_both   = (have_aw_q | awvalid) & (have_w_q | wvalid);

    // Whichever half arrives on the final handshake comes straight off the bus.
    assign cur_addr = have_aw_q ? aw_addr_q : awaddr;
    assign cur_size = have_aw_q ? aw_size_q : awsize;
    assign cur_data = have_w_q ? w_data_q : wdata;
    assign cur_strb = have_w_q ? w_strb_q : wstrb;
    assign w_off    = cur_addr - BASE_ADDR;
    assign w_err    = (w_off >= SPAN) | size_err(cur_size, cur_addr[1:0]);
    assign w_idx    = w_off[IDX_W+1:2];

    assign w_cnt_load = (w_state == W_IDLE) && w_both;
    // Reset on the commit edge drops the pending write.
    assign commit = ~reset & (((w_state == W_IDLE) && w_both && (WRITE_LATENCY == 1)) ||
                              ((w_state == W_WAIT) && w_done));

    ysyx_23060236_lat_cnt #(
        .WIDTH (W_CW)
    ) u_w_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (W_CW'(W_LOAD)),
        .done     (w_done)
    );

    // SRAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (commit && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_strb[b]) begin
                    mem[w_idx][8*b +: 8] <= cur_data[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: collect AW and W in any order, wait out the latency, hold B until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state   <= W_IDLE;
            have_aw_q <= 1'b0;
            have_w_q  <= 1'b0;
            aw_addr_q <= '0;
            aw_size_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr;
                        aw_size_q <= awsize;
                        have_aw_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        have_w_q <= 1'b1;
                    end
                    if (w_both) begin
                        if (WRITE_LATENCY == 1) begin
                            bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
                            bvalid  <= 1'b1;
                            w_state <= W_RESP;
                        end else begin
                            w_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_done) begin
                        bresp   <= w_err ? RESP_SLVERR : RESP_OKAY;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        have_aw_q <= 1'b0;
                        have_w_q  <= 1'b0;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_axi_sram.sv
// Self-checking bench for ysyx_23060236_axi_sram: table of transactions plus corner-case sequences.
module tb_ysyx_23060236_axi_sram;
    import ysyx_23060236_axi_pkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic [2:0]  arsize;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [2:0]  awsize;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clock = ~clock;

    ysyx_23060236_axi_sram dut (
        .clock   (clock),
        .reset   (reset),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arsize  (arsize),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awsize  (awsize),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    exp_t rexp_q[$];
    exp_t bexp_q[$];
    vec_t vecs[19];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] edata, input logic [1:0] eresp,
                           input int hold, input string name);
        exp_t e;
        int   n;
        e.data = edata;
        e.resp = eresp;
        rexp_q.push_back(e);
        @(negedge clock);
        araddr  = addr;
        arsize  = size;
        arvalid = 1'b1;
        rready  = (hold == 0);
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!arready) begin
            arvalid = 1'b0;
            void'(rexp_q.pop_back());
            timeout({name, "_ar"});
            return;
        end
        @(posedge clock);
        n = 0;
        do begin
            @(negedge clock);
            arvalid = 1'b0;
            n++;
        end while (!rvalid && n < 20);
        if (!rvalid) begin
            void'(rexp_q.pop_front());
            timeout({name, "_r"});
            return;
        end
        check({name, "_rlat"}, 32'(n), 32'(LAT));
        e = rexp_q.pop_front();
        check({name, "_rdata"}, rdata, e.data);
        check({name, "_rresp"}, 32'(rresp), 32'(e.resp));
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check({name, "_hold_rvalid"}, 32'(rvalid), 32'd1);
            check({name, "_hold_rdata"}, rdata, e.data);
            check({name, "_hold_rresp"}, 32'(rresp), 32'(e.resp));
            check({name, "_hold_arready"}, 32'(arready), 32'd0);
        end
        rready = 1'b1;
        @(negedge clock);
        check({name, "_rvalid_drop"}, 32'(rvalid), 32'd0);
        check({name, "_arready_back"}, 32'(arready), 32'd1);
        rready = 1'b0;
    endtask

    // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap = cycles between them.
    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int gap, input int hold,
                            input logic [1:0] eresp, input string name);
        exp_t e;
        int   n;
        int   aw_start;
        int   w_start;
        bit   aw_done;
        bit   w_done;
        bit   aw_fire;
        bit   w_fire;
        e.data = '0;
        e.resp = eresp;
        bexp_q.push_back(e);
        aw_start = (order == 2) ? gap : 0;
        w_start  = (order == 1) ? gap : 0;
        aw_done  = 1'b0;
        w_done   = 1'b0;
        awaddr   = addr;
        awsize   = size;
        wdata    = data;
        wstrb    = strb;
        bready   = (hold == 0);
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            @(negedge clock);
            if (aw_done && !w_done) check({name, "_awready_low"}, 32'(awready), 32'd0);
            if (w_done && !aw_done) check({name, "_wready_low"}, 32'(wready), 32'd0);
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clock);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
        end
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            void'(bexp_q.pop_back());
            timeout({name, "_aw_w"});
            return;
        end
        n = 0;
        do begin
            @(negedge clock);
            awvalid = 1'b0;
            wvalid  = 1'b0;
            n++;
        end while (!bvalid && n < 20);
        if (!bvalid) begin
            void'(bexp_q.pop_front());
            timeout({name, "_b"});
            return;
        end
        check({name, "_blat"}, 32'(n), 32'(LAT));
        e = bexp_q.pop_front();
        check({name, "_bresp"}, 32'(bresp), 32'(e.resp));
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check({name, "_hold_bvalid"}, 32'(bvalid), 32'd1);
            check({name, "_hold_bresp"}, 32'(bresp), 32'(e.resp));
            check({name, "_hold_awready"}, 32'(awready), 32'd0);
            check({name, "_hold_wready"}, 32'(wready), 32'd0);
        end
        bready = 1'b1;
        @(negedge clock);
        check({name, "_bvalid_drop"}, 32'(bvalid), 32'd0);
        check({name, "_awready_back"}, 32'(awready), 32'd1);
        check({name, "_wready_back"}, 32'(wready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        araddr  = '0;
        arsize  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awsize  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;

        //                wr    addr           size  data           strb     exp_data       exp_resp
        vecs[0]  = '{1'b1, 32'h8000_0000, 3'd2, 32'hDEAD_BEEF, 4'hF,   32'h0,         RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h8000_0000, 3'd2, 32'h0,         4'h0,   32'hDEAD_BEEF, RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h8000_0004, 3'd2, 32'h1122_3344, 4'hF,   32'h0,         RESP_OKAY};
        vecs[3]  = '{1'b1, 32'h8000_0008, 3'd2, 32'hCAFE_F00D, 4'hF,   32'h0,         RESP_OKAY};
        vecs[4]  = '{1'b1, 32'h8000_0FFC, 3'd2, 32'hA5A5_5A5A, 4'hF,   32'h0,         RESP_OKAY};
        vecs[5]  = '{1'b0, 32'h8000_0FFC, 3'd2, 32'h0,         4'h0,   32'hA5A5_5A5A, RESP_OKAY};
        vecs[6]  = '{1'b0, 32'h8000_1000, 3'd2, 32'h0,         4'h0,   32'h0,         RESP_SLVERR};
        vecs[7]  = '{1'b0, 32'h8000_0001, 3'd1, 32'h0,         4'h0,   32'h0,         RESP_SLVERR};
        vecs[8]  = '{1'b0, 32'h8000_0002, 3'd1, 32'h0,         4'h0,   32'hDEAD_BEEF, RESP_OKAY};
        vecs[9]  = '{1'b0, 32'h8000_0003, 3'd0, 32'h0,         4'h0,   32'hDEAD_BEEF, RESP_OKAY};
        vecs[10] = '{1'b0, 32'h8000_0004, 3'd3, 32'h0,         4'h0,   32'h0,         RESP_SLVERR};
        vecs[11] = '{1'b1, 32'h7FFF_FFFC, 3'd2, 32'hFFFF_FFFF, 4'hF,   32'h0,         RESP_SLVERR};
        vecs[12] = '{1'b0, 32'h8000_0FFC, 3'd2, 32'h0,         4'h0,   32'hA5A5_5A5A, RESP_OKAY};
        vecs[13] = '{1'b1, 32'h8000_0009, 3'd2, 32'h0000_0000, 4'hF,   32'h0,         RESP_SLVERR};
        vecs[14] = '{1'b1, 32'h8000_0008, 3'd2, 32'h0000_0000, 4'h0,   32'h0,         RESP_OKAY};
        vecs[15] = '{1'b0, 32'h8000_0008, 3'd2, 32'h0,         4'h0,   32'hCAFE_F00D, RESP_OKAY};
        vecs[16] = '{1'b1, 32'h8000_0000, 3'd1, 32'h0000_1234, 4'b0011, 32'h0,        RESP_OKAY};
        vecs[17] = '{1'b0, 32'h8000_0000, 3'd2, 32'h0,         4'h0,   32'hDEAD_1234, RESP_OKAY};
        vecs[18] = '{1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0,         4'h0,   32'h0,         RESP_SLVERR};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].strb,
                         i % 3, 1 + (i % 2), 0, vecs[i].exp_resp, $sformatf("vec%0d", i));
            end else begin
                do_read(vecs[i].addr, vecs[i].size, vecs[i].exp_data, vecs[i].exp_resp,
                        0, $sformatf("vec%0d", i));
            end
        end

        // Byte store with W ahead of AW; latency counts from the AW handshake.
        do_write(32'h8000_0006, SIZE_B, 32'h00AB_0000, 4'b0100, 2, 2, 0, RESP_OKAY, "bytest");
        do_read(32'h8000_0004, SIZE_W, 32'h11AB_3344, RESP_OKAY, 0, "bytest_rd");

        // Backpressure on both response channels.
        do_read(32'h8000_0000, SIZE_W, 32'hDEAD_1234, RESP_OKAY, 5, "bp_rd");
        do_write(32'h8000_000C, SIZE_W, 32'h5555_AAAA, 4'hF, 0, 0, 5, RESP_OKAY, "bp_wr");
        do_read(32'h8000_000C, SIZE_W, 32'h5555_AAAA, RESP_OKAY, 0, "bp_rd2");

        // Read sample and write commit land on the same edge: old data returned.
        fork
            do_read(32'h8000_0008, SIZE_W, 32'hCAFE_F00D, RESP_OKAY, 0, "sim_rd");
            do_write(32'h8000_0008, SIZE_W, 32'h0102_0304, 4'hF, 0, 0, 0, RESP_OKAY, "sim_wr");
        join
        do_read(32'h8000_0008, SIZE_W, 32'h0102_0304, RESP_OKAY, 0, "sim_rd2");

        // Reset while the write sits in its wait state: nothing is committed.
        @(negedge clock);
        awaddr  = 32'h8000_0004;
        awsize  = SIZE_W;
        wdata   = 32'hFFFF_FFFF;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        check("rstw_ready_pre", 32'({awready, wready}), 32'd3);
        @(posedge clock);
        @(negedge clock);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstw_bvalid", 32'(bvalid), 32'd0);
        check("rstw_arready", 32'(arready), 32'd1);
        check("rstw_awready", 32'(awready), 32'd1);
        check("rstw_wready", 32'(wready), 32'd1);
        @(negedge clock);
        check("rstw_bvalid_late", 32'(bvalid), 32'd0);
        do_read(32'h8000_0004, SIZE_W, 32'h11AB_3344, RESP_OKAY, 0, "rstw_rd");

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
